// File: rtl/timer_pkg.sv
// Shared definitions for the microwave cook-timer control slice:
// FSM state encoding and BCD digit limits.
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_LOAD  = 3'd2,
    ST_COOK  = 3'd3,
    ST_PAUSE = 3'd4,
    ST_CLEAR = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Largest legal BCD digit and largest legal seconds-tens digit.
  localparam int BCD_MAX   = 9;
  localparam int SEC_T_MAX = 5;

endpackage

// File: rtl/keypad_entry_reg.sv
// Three-digit BCD M:SS entry register. Digits shift in from the right
// (seconds-ones) and fall off the left (minutes). Flags whether the
// current entry is zero and whether it is a startable time.
module keypad_entry_reg
  import timer_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          clearn,
  input  logic          shift_en,
  input  logic          clr,
  input  logic [DW-1:0] digit,
  output logic          key_ok,
  output logic [DW-1:0] min,
  output logic [DW-1:0] sec_t,
  output logic [DW-1:0] sec_o,
  output logic          entry_zero,
  output logic          entry_valid
);

  localparam logic [DW-1:0] DIG_MAX   = DW'(BCD_MAX);
  localparam logic [DW-1:0] SEC_T_LIM = DW'(SEC_T_MAX);

  // A key only takes effect when the FSM allows it and the digit is BCD.
  always_comb begin
    key_ok      = shift_en && (digit <= DIG_MAX);
    entry_zero  = (min == '0) && (sec_t == '0) && (sec_o == '0);
    entry_valid = !entry_zero && (sec_t <= SEC_T_LIM);
  end

  // Shift register: clear has priority over a new digit.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      min   <= '0;
      sec_t <= '0;
      sec_o <= '0;
    end else if (clr) begin
      min   <= '0;
      sec_t <= '0;
      sec_o <= '0;
    end else if (key_ok) begin
      min   <= sec_t;
      sec_t <= sec_o;
      sec_o <= digit;
    end
  end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Cook-timer sequencing FSM. Collects keypad digits, loads/enables/clears
// the external BCD down-counter chain, gates the magnetron and holds the
// done indicator for DONE_CYCLES cycles at the end of a cook.
module microwave_timer_ctrl
  import timer_pkg::*;
#(
  parameter int DONE_CYCLES = 8,
  parameter int DW          = 4
) (
  input  logic          clk,
  input  logic          clearn,
  input  logic          key_valid,
  input  logic [DW-1:0] key_digit,
  input  logic          start,
  input  logic          stop,
  input  logic          door_closed,
  input  logic          tick_1hz,
  input  logic          zero_flag,
  output logic [DW-1:0] ld_min,
  output logic [DW-1:0] ld_sec_t,
  output logic [DW-1:0] ld_sec_o,
  output logic          load_n,
  output logic          count_en,
  output logic          cnt_clear_n,
  output logic          mag_on,
  output logic          done,
  output logic          err
);

  localparam int            CW        = $clog2(DONE_CYCLES + 1);
  localparam logic [CW-1:0] DONE_LAST = CW'(DONE_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] done_cnt;
  logic          key_en;
  logic          key_ok;
  logic          entry_zero;
  logic          entry_valid;
  logic          entry_clr;
  logic          start_ok;

  // Keys are accepted only while editing; a key arriving with start is
  // dropped so start judges the entry as it stood before the key.
  always_comb begin
    key_en    = key_valid && !start &&
                ((state == ST_IDLE) || (state == ST_ENTRY));
    entry_clr = (state == ST_CLEAR);
    start_ok  = entry_valid && door_closed;
    count_en  = (state == ST_COOK) && tick_1hz && door_closed;
  end

  keypad_entry_reg #(
    .DW (DW)
  ) u_entry (
    .clk         (clk),
    .clearn      (clearn),
    .shift_en    (key_en),
    .clr         (entry_clr),
    .digit       (key_digit),
    .key_ok      (key_ok),
    .min         (ld_min),
    .sec_t       (ld_sec_t),
    .sec_o       (ld_sec_o),
    .entry_zero  (entry_zero),
    .entry_valid (entry_valid)
  );

  // Sequencing FSM with registered control outputs and the done-hold counter.
  // In IDLE a start is silently ignored unless a kept entry (left over from
  // a finished cook) is startable, which lets a second start re-run it.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state       <= ST_IDLE;
      done_cnt    <= '0;
      load_n      <= 1'b1;
      cnt_clear_n <= 1'b1;
      mag_on      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      err         <= 1'b0;
      load_n      <= 1'b1;
      cnt_clear_n <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start && !stop && start_ok) begin
            state  <= ST_LOAD;
            load_n <= 1'b0;
          end else if (key_ok) begin
            state <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (stop) begin
            state       <= ST_CLEAR;
            cnt_clear_n <= 1'b0;
          end else if (start) begin
            if (start_ok) begin
              state  <= ST_LOAD;
              load_n <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          state  <= ST_COOK;
          mag_on <= 1'b1;
        end
        ST_COOK: begin
          if (zero_flag) begin
            state    <= ST_DONE;
            mag_on   <= 1'b0;
            done     <= 1'b1;
            done_cnt <= '0;
          end else if (stop || !door_closed) begin
            state  <= ST_PAUSE;
            mag_on <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            state       <= ST_CLEAR;
            cnt_clear_n <= 1'b0;
          end else if (start && door_closed) begin
            state  <= ST_COOK;
            mag_on <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state <= ST_IDLE;
        end
        ST_DONE: begin
          if (stop) begin
            state       <= ST_CLEAR;
            done        <= 1'b0;
            cnt_clear_n <= 1'b0;
          end else if (done_cnt == DONE_LAST) begin
            state <= ST_IDLE;
            done  <= 1'b0;
          end else begin
            done_cnt <= done_cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          mag_on <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Scoreboard bench for microwave_timer_ctrl: each stimulus step queues the
// expected output vector for its cycle; a negedge monitor pops and compares.
module tb_microwave_timer_ctrl;

  logic       clk = 1'b0;
  logic       clearn = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       door_closed = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       zero_flag = 1'b0;
  logic [3:0] ld_min, ld_sec_t, ld_sec_o;
  logic       load_n, count_en, cnt_clear_n, mag_on, done, err;

  microwave_timer_ctrl #(.DONE_CYCLES(8), .DW(4)) dut (
    .clk         (clk),
    .clearn      (clearn),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop        (stop),
    .door_closed (door_closed),
    .tick_1hz    (tick_1hz),
    .zero_flag   (zero_flag),
    .ld_min      (ld_min),
    .ld_sec_t    (ld_sec_t),
    .ld_sec_o    (ld_sec_o),
    .load_n      (load_n),
    .count_en    (count_en),
    .cnt_clear_n (cnt_clear_n),
    .mag_on      (mag_on),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          t;
    string       name;
    logic [17:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [17:0] obs;
  assign obs = {ld_min, ld_sec_t, ld_sec_o, load_n, count_en, cnt_clear_n,
                mag_on, done, err};

  // Full output vector: entry digits, then load_n,count_en,cnt_clear_n,mag_on,done,err.
  function automatic logic [17:0] E(input logic [3:0] m, input logic [3:0] t,
                                    input logic [3:0] o, input logic ln,
                                    input logic ce, input logic cn,
                                    input logic mg, input logic dn,
                                    input logic er);
    return {m, t, o, ln, ce, cn, mg, dn, er};
  endfunction

  // Quiet outputs (idle/entry/pause) with the given entry digits.
  function automatic logic [17:0] Q(input logic [3:0] m, input logic [3:0] t,
                                    input logic [3:0] o);
    return {m, t, o, 6'b101000};
  endfunction

  task automatic compare(input string name, input logic [17:0] got,
                         input logic [17:0] ex);
    n_vec++;
    if (got !== ex) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h (cycle %0d)", name, got, ex, cyc);
    end
  endtask

  // Monitor: compare every queued expectation in the cycle it is due.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].t <= cyc) begin
      e = sb.pop_front();
      if (e.t < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: stale expectation for cycle %0d at cycle %0d", e.name, e.t, cyc);
      end else begin
        compare(e.name, obs, e.exp);
      end
    end
  end

  task automatic step(input string name, input logic kv, input logic [3:0] kd,
                      input logic st, input logic sp, input logic dc,
                      input logic tk, input logic zf, input logic [17:0] ex);
    @(posedge clk);
    #1;
    key_valid   = kv;
    key_digit   = kd;
    start       = st;
    stop        = sp;
    door_closed = dc;
    tick_1hz    = tk;
    zero_flag   = zf;
    sb.push_back('{t: cyc, name: name, exp: ex});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 clearn = 1'b0;
    #1 compare("reset_init", obs, Q(0, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #1 clearn = 1'b1;

    // Keys 1,3,0 -> 1:30, start, load pulse, cook with ticks
    step("k1",        1, 4'd1, 0, 0, 1, 0, 0, Q(0, 0, 0));
    step("k3",        1, 4'd3, 0, 0, 1, 0, 0, Q(0, 0, 1));
    step("k0",        1, 4'd0, 0, 0, 1, 0, 0, Q(0, 1, 3));
    step("start130",  0, 4'd0, 1, 0, 1, 0, 0, Q(1, 3, 0));
    step("load130",   0, 4'd0, 0, 0, 1, 0, 0, E(1, 3, 0, 0, 0, 1, 0, 0, 0));
    step("cook130",   0, 4'd0, 0, 0, 1, 0, 0, E(1, 3, 0, 1, 0, 1, 1, 0, 0));
    step("tick_a",    0, 4'd0, 0, 0, 1, 1, 0, E(1, 3, 0, 1, 1, 1, 1, 0, 0));
    step("notick",    0, 4'd0, 0, 0, 1, 0, 0, E(1, 3, 0, 1, 0, 1, 1, 0, 0));
    step("tick_b",    0, 4'd0, 0, 0, 1, 1, 0, E(1, 3, 0, 1, 1, 1, 1, 0, 0));

    // zero_flag -> done for exactly 8 cycles, then IDLE with 1:30 kept
    step("zero",      0, 4'd0, 0, 0, 1, 0, 1, E(1, 3, 0, 1, 0, 1, 1, 0, 0));
    for (int i = 0; i < 8; i++)
      step($sformatf("done_hi%0d", i), 0, 4'd0, 0, 0, 1, 0, 0, E(1, 3, 0, 1, 0, 1, 0, 1, 0));
    step("done_lo",   0, 4'd0, 0, 0, 1, 0, 0, Q(1, 3, 0));
    step("restart",   0, 4'd0, 1, 0, 1, 0, 0, Q(1, 3, 0));
    step("reload",    0, 4'd0, 0, 0, 1, 0, 0, E(1, 3, 0, 0, 0, 1, 0, 0, 0));
    step("recook",    0, 4'd0, 0, 0, 1, 0, 0, E(1, 3, 0, 1, 0, 1, 1, 0, 0));

    // Door opens in COOK -> PAUSE, resume without reload
    step("door_open", 0, 4'd0, 0, 0, 0, 1, 0, E(1, 3, 0, 1, 0, 1, 1, 0, 0));
    step("paused",    0, 4'd0, 0, 0, 0, 1, 0, Q(1, 3, 0));
    step("pause_tick",0, 4'd0, 0, 0, 1, 1, 0, Q(1, 3, 0));
    step("resume",    0, 4'd0, 1, 0, 1, 0, 0, Q(1, 3, 0));
    step("resumed",   0, 4'd0, 0, 0, 1, 0, 0, E(1, 3, 0, 1, 0, 1, 1, 0, 0));
    step("res_tick",  0, 4'd0, 0, 0, 1, 1, 0, E(1, 3, 0, 1, 1, 1, 1, 0, 0));

    // stop -> PAUSE; start+stop in PAUSE -> CLEAR -> IDLE 0:00
    step("stop_cook", 0, 4'd0, 0, 1, 1, 0, 0, E(1, 3, 0, 1, 0, 1, 1, 0, 0));
    step("st_sp",     0, 4'd0, 1, 1, 1, 0, 0, Q(1, 3, 0));
    step("clearing",  0, 4'd0, 0, 0, 1, 0, 0, E(1, 3, 0, 1, 0, 0, 0, 0, 0));
    step("cleared",   0, 4'd0, 0, 0, 1, 0, 0, Q(0, 0, 0));

    // 0:75 rejected
    step("k0b",       1, 4'd0, 0, 0, 1, 0, 0, Q(0, 0, 0));
    step("k7",        1, 4'd7, 0, 0, 1, 0, 0, Q(0, 0, 0));
    step("k5",        1, 4'd5, 0, 0, 1, 0, 0, Q(0, 0, 7));
    step("start075",  0, 4'd0, 1, 0, 1, 0, 0, Q(0, 7, 5));
    step("err075",    0, 4'd0, 0, 0, 1, 0, 0, E(0, 7, 5, 1, 0, 1, 0, 0, 1));
    step("err075_end",0, 4'd0, 0, 0, 1, 0, 0, Q(0, 7, 5));

    // 7:51 with door open rejected
    step("k1b",       1, 4'd1, 0, 0, 1, 0, 0, Q(0, 7, 5));
    step("start_door",0, 4'd0, 1, 0, 0, 0, 0, Q(7, 5, 1));
    step("err_door",  0, 4'd0, 0, 0, 1, 0, 0, E(7, 5, 1, 1, 0, 1, 0, 0, 1));
    step("err_door_end",0, 4'd0, 0, 0, 1, 0, 0, Q(7, 5, 1));

    // stop in ENTRY clears; 0:00 start rejected
    step("stop_entry",0, 4'd0, 0, 1, 1, 0, 0, Q(7, 5, 1));
    step("clear_entry",0, 4'd0, 0, 0, 1, 0, 0, E(7, 5, 1, 1, 0, 0, 0, 0, 0));
    step("idle_again",0, 4'd0, 0, 0, 1, 0, 0, Q(0, 0, 0));
    step("k0c",       1, 4'd0, 0, 0, 1, 0, 0, Q(0, 0, 0));
    step("start000",  0, 4'd0, 1, 0, 1, 0, 0, Q(0, 0, 0));
    step("err000",    0, 4'd0, 0, 0, 1, 0, 0, E(0, 0, 0, 1, 0, 1, 0, 0, 1));

    // Non-BCD digit ignored; key with start is dropped, start sees 0:00
    step("bad_digit", 1, 4'd12, 0, 0, 1, 0, 0, Q(0, 0, 0));
    step("bad_dig_chk",0, 4'd0, 0, 0, 1, 0, 0, Q(0, 0, 0));
    step("key_start", 1, 4'd5, 1, 0, 1, 0, 0, Q(0, 0, 0));
    step("err_keyst", 0, 4'd0, 0, 0, 1, 0, 0, E(0, 0, 0, 1, 0, 1, 0, 0, 1));
    step("key_dropped",0, 4'd0, 0, 0, 1, 0, 0, Q(0, 0, 0));

    // 0:59 accepted; zero_flag beats stop/door; stop in DONE clears early
    step("k5c",       1, 4'd5, 0, 0, 1, 0, 0, Q(0, 0, 0));
    step("k9",        1, 4'd9, 0, 0, 1, 0, 0, Q(0, 0, 5));
    step("start059",  0, 4'd0, 1, 0, 1, 0, 0, Q(0, 5, 9));
    step("load059",   0, 4'd0, 0, 0, 1, 0, 0, E(0, 5, 9, 0, 0, 1, 0, 0, 0));
    step("cook059",   0, 4'd0, 0, 0, 1, 0, 0, E(0, 5, 9, 1, 0, 1, 1, 0, 0));
    step("zero_stop", 0, 4'd0, 0, 1, 0, 0, 1, E(0, 5, 9, 1, 0, 1, 1, 0, 0));
    step("done059",   0, 4'd0, 0, 0, 1, 0, 0, E(0, 5, 9, 1, 0, 1, 0, 1, 0));
    step("stop_done", 0, 4'd0, 0, 1, 1, 0, 0, E(0, 5, 9, 1, 0, 1, 0, 1, 0));
    step("clear_done",0, 4'd0, 0, 0, 1, 0, 0, E(0, 5, 9, 1, 0, 0, 0, 0, 0));
    step("idle_done", 0, 4'd0, 0, 0, 1, 0, 0, Q(0, 0, 0));

    // Async reset mid-COOK, checked between clock edges
    step("k2",        1, 4'd2, 0, 0, 1, 0, 0, Q(0, 0, 0));
    step("start002",  0, 4'd0, 1, 0, 1, 0, 0, Q(0, 0, 2));
    step("load002",   0, 4'd0, 0, 0, 1, 0, 0, E(0, 0, 2, 0, 0, 1, 0, 0, 0));
    step("cook002",   0, 4'd0, 0, 0, 1, 1, 0, E(0, 0, 2, 1, 1, 1, 1, 0, 0));
    @(negedge clk);
    #2 clearn = 1'b0;
    #1 compare("async_reset", obs, Q(0, 0, 0));
    step("held_reset",0, 4'd0, 0, 0, 1, 1, 0, Q(0, 0, 0));
    #1 clearn = 1'b1;
    step("post_reset",0, 4'd0, 0, 0, 1, 1, 0, Q(0, 0, 0));

    repeat (2) @(posedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
